// File: rtl/iact_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iact_bank_arbiter_pkg
// Brief    : Shared GLB bank-arbiter state encodings, widths and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package iact_bank_arbiter_pkg;

    localparam int IACT_ADDR_W = 10;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WRITE = 2'd1,
        ARB_READ  = 2'd2
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iact_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : iact_bank_arbiter_if
// Brief    : Loader / PE-port / bank control bundle around the iact arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface iact_bank_arbiter_if
    import iact_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = IACT_ADDR_W
);
    logic                        wr_req;
    logic                        wr_grant;
    logic                        wr_done;
    logic [NUM_REQ-1:0]          rd_req;
    logic [NUM_REQ*ADDR_W-1:0]   rd_addr;
    logic [NUM_REQ-1:0]          rd_grant;
    logic [NUM_REQ-1:0]          rd_done;
    logic                        loaded;
    logic                        bank_write_en;
    logic                        bank_write_done;
    logic                        bank_read_en;
    logic [ADDR_W-1:0]           bank_read_addr;
    logic                        bank_read_done;

    modport master (
        input  wr_req, rd_req, rd_addr, bank_write_done, bank_read_done,
        output wr_grant, wr_done, rd_grant, rd_done, loaded,
               bank_write_en, bank_read_en, bank_read_addr
    );

    modport slave (
        output wr_req, rd_req, rd_addr, bank_write_done, bank_read_done,
        input  wr_grant, wr_done, rd_grant, rd_done, loaded,
               bank_write_en, bank_read_en, bank_read_addr
    );
endinterface
`default_nettype wire

// File: rtl/iact_bank_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : iact_bank_arbiter_rr_picker
// Brief    : Combinational round-robin pick: first set request from i_ptr up.
// Revision : 1.0 - initial release
// ============================================================================
module iact_bank_arbiter_rr_picker #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [PW-1:0] i_ptr,
    output logic      [N-1:0]  o_grant,
    output logic      [PW-1:0] o_idx,
    output logic               o_valid
);
    int w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = PW'(w_cand);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/iact_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iact_bank_arbiter
// Brief    : Serialises loader writes and round-robin PE reads onto one iact bank.
// Revision : 1.0 - initial release
// ============================================================================
module iact_bank_arbiter
    import iact_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = IACT_ADDR_W
) (
    input  wire logic          clock,
    input  wire logic          reset,
    iact_bank_arbiter_if.master bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          r_state,   w_state_nxt;
    logic [PW-1:0]       r_rr_ptr,  w_rr_ptr_nxt;
    logic [NUM_REQ-1:0]  r_owner,   w_owner_nxt;
    logic [ADDR_W-1:0]   r_addr,    w_addr_nxt;
    logic                r_loaded,  w_loaded_nxt;
    logic                r_wr_en,   w_wr_en_nxt;
    logic                r_rd_en,   w_rd_en_nxt;

    logic [NUM_REQ-1:0]  w_pick_grant;
    logic [PW-1:0]       w_pick_idx;
    logic                w_pick_valid;

    iact_bank_arbiter_rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_picker (
        .i_req   (bus.rd_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_addr_nxt   = r_addr;
        w_loaded_nxt = r_loaded;
        w_wr_en_nxt  = 1'b0;
        w_rd_en_nxt  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (bus.wr_req) begin
                    // Tile is about to be overwritten, so it stops being readable now.
                    w_state_nxt  = ARB_WRITE;
                    w_loaded_nxt = 1'b0;
                    w_wr_en_nxt  = 1'b1;
                end else if (r_loaded && w_pick_valid) begin
                    w_state_nxt  = ARB_READ;
                    w_owner_nxt  = w_pick_grant;
                    w_addr_nxt   = bus.rd_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                    w_rr_ptr_nxt = PW'(rr_next(int'(w_pick_idx), NUM_REQ));
                    w_rd_en_nxt  = 1'b1;
                end
            end
            ARB_WRITE: begin
                if (bus.bank_write_done) begin
                    w_state_nxt  = ARB_IDLE;
                    w_loaded_nxt = 1'b1;
                end
            end
            ARB_READ: begin
                if (bus.bank_read_done) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_addr   <= '0;
            r_loaded <= 1'b0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_addr   <= w_addr_nxt;
            r_loaded <= w_loaded_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_rd_en  <= w_rd_en_nxt;
        end
    end

    // Done pulses pass straight through, gated by the state that owns them.
    assign bus.wr_grant       = (r_state == ARB_WRITE);
    assign bus.wr_done        = (r_state == ARB_WRITE) && bus.bank_write_done;
    assign bus.rd_grant       = (r_state == ARB_READ) ? r_owner : '0;
    assign bus.rd_done        = (r_state == ARB_READ && bus.bank_read_done) ? r_owner : '0;
    assign bus.loaded         = r_loaded;
    assign bus.bank_write_en  = r_wr_en;
    assign bus.bank_read_en   = r_rd_en;
    assign bus.bank_read_addr = r_addr;
endmodule
`default_nettype wire

// File: tb/tb_iact_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iact_bank_arbiter
// Brief    : Random loader/PE/bank traffic scored against a cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iact_bank_arbiter;
    import iact_bank_arbiter_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 10;
    localparam int N_CYC   = 4000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    iact_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

    iact_bank_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int               busy;     // 0 none, 1 write, 2 read
        int               owner;
        logic [ADDR_W-1:0] addr;
        bit               loaded;
        bit               wen;
        bit               ren;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // reference model state
    int               m_busy   = 0;
    int               m_owner  = 0;
    int               m_ptr    = 0;
    bit               m_loaded = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;

    // monitor-owned observation counters
    int wr_done_cnt = 0;
    int rd_done_cnt [NUM_REQ];
    int grant_cnt   [NUM_REQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance one cycle from the inputs seen at this edge.
    always @(posedge clock) begin
        exp_t e;
        bit   wen;
        bit   ren;
        int   c;
        wen = 1'b0;
        ren = 1'b0;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_loaded = 1'b0; m_addr = '0;
        end else if (m_busy == 0) begin
            if (bus.wr_req) begin
                m_busy = 1; m_loaded = 1'b0; wen = 1'b1;
            end else if (m_loaded && bus.rd_req != '0) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (bus.rd_req[c]) m_owner = c;
                end
                m_addr = bus.rd_addr[m_owner*ADDR_W +: ADDR_W];
                m_ptr  = (m_owner + 1) % NUM_REQ;
                m_busy = 2;
                ren    = 1'b1;
            end
        end else if (m_busy == 1) begin
            if (bus.bank_write_done) begin m_busy = 0; m_loaded = 1'b1; end
        end else begin
            if (bus.bank_read_done) m_busy = 0;
        end
        e.busy = m_busy; e.owner = m_owner; e.addr = m_addr;
        e.loaded = m_loaded; e.wen = wen; e.ren = ren;
        sb_q.push_back(e);
    end

    // Monitor: pop expectation and compare every DUT output mid-cycle.
    always @(negedge clock) begin
        exp_t             e;
        logic [NUM_REQ-1:0] g;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            g = '0;
            if (e.busy == 2) g[e.owner] = 1'b1;
            chk("wr_grant",       32'(bus.wr_grant),       32'(e.busy == 1));
            chk("wr_done",        32'(bus.wr_done),        32'(e.busy == 1 && bus.bank_write_done));
            chk("rd_grant",       32'(bus.rd_grant),       32'(g));
            chk("rd_done",        32'(bus.rd_done),        32'(bus.bank_read_done ? g : '0));
            chk("loaded",         32'(bus.loaded),         32'(e.loaded));
            chk("bank_write_en",  32'(bus.bank_write_en),  32'(e.wen));
            chk("bank_read_en",   32'(bus.bank_read_en),   32'(e.ren));
            chk("bank_read_addr", 32'(bus.bank_read_addr), 32'(e.addr));
        end
        if (bus.wr_done) wr_done_cnt++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.rd_done[i]) rd_done_cnt[i]++;
            if (bus.bank_read_en && bus.rd_grant[i]) grant_cnt[i]++;
        end
    end

    // Stimulus: loader, PE requesters and a bank with random latency.
    initial begin
        int wr_ack;
        int rd_ack [NUM_REQ];
        int wcnt, rcnt, lat;
        bit did_reset;
        wr_ack = 0; wcnt = 0; rcnt = 0; did_reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_ack[i] = 0; rd_done_cnt[i] = 0; grant_cnt[i] = 0;
        end
        bus.wr_req = 1'b0; bus.rd_req = '0; bus.rd_addr = '0;
        bus.bank_write_done = 1'b0; bus.bank_read_done = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clock);
            #1;
            reset = 1'b0;
            if (!did_reset && cyc > N_CYC/2 && bus.wr_grant) begin
                reset = 1'b1;
                did_reset = 1'b1;
            end

            bus.bank_write_done = 1'b0;
            bus.bank_read_done  = 1'b0;
            if (reset) begin
                wcnt = 0; rcnt = 0;
            end else begin
                if (wcnt > 0) begin wcnt--; if (wcnt == 0) bus.bank_write_done = 1'b1; end
                if (bus.bank_write_en) begin
                    lat = $urandom_range(0, 4);
                    if (lat == 0) bus.bank_write_done = 1'b1; else wcnt = lat;
                end else if (wcnt == 0 && !bus.bank_write_done && $urandom_range(0, 15) == 0)
                    bus.bank_write_done = 1'b1;
                if (rcnt > 0) begin rcnt--; if (rcnt == 0) bus.bank_read_done = 1'b1; end
                if (bus.bank_read_en) begin
                    lat = $urandom_range(0, 4);
                    if (lat == 0) bus.bank_read_done = 1'b1; else rcnt = lat;
                end else if (rcnt == 0 && !bus.bank_read_done && $urandom_range(0, 15) == 0)
                    bus.bank_read_done = 1'b1;
            end

            if (wr_done_cnt != wr_ack) begin
                wr_ack = wr_done_cnt;
                bus.wr_req = 1'b0;
            end else if (!bus.wr_req && $urandom_range(0, 29) == 0) begin
                bus.wr_req = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rd_done_cnt[i] != rd_ack[i]) begin
                    rd_ack[i] = rd_done_cnt[i];
                    bus.rd_req[i] = 1'b0;
                end else if (bus.rd_grant[i] && $urandom_range(0, 7) == 0) begin
                    bus.rd_req[i] = 1'b0;
                end else if (!bus.rd_req[i] && !bus.rd_grant[i] && $urandom_range(0, 3) == 0) begin
                    bus.rd_req[i] = 1'b1;
                    bus.rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                end
            end
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        chk("reset_mid_write_hit", 32'(did_reset), 32'd1);
        for (int i = 0; i < NUM_REQ; i++) begin
            vectors++;
            if (grant_cnt[i] == 0) begin
                miscompares++;
                $display("FAIL no_starvation_%0d: got %0d grants expected >0", i, grant_cnt[i]);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
